// File: rtl/ct_ifu_icache_predecd_wr_ctrl.sv
// Predecode array0 requester: arbitrates fetch reads, FIFO-buffered refill line writes and a
// full-array invalidate sweep. Optional write-starvation guard under IFU_PREDECD_STARVE_EN.
module ct_ifu_icache_predecd_wr_ctrl #(
  parameter int unsigned WIDTH      = 12,
  parameter int unsigned LINE_BEATS = 4,
  parameter int unsigned STARVE_MAX = 7
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst,
  input  logic        fetch_req,
  input  logic [15:0] fetch_index,
  output logic        fetch_gnt,
  output logic        rd_vld,
  output logic [31:0] rd_data,
  input  logic        refill_start,
  input  logic [15:0] refill_line_index,
  input  logic        refill_vld,
  output logic        refill_rdy,
  input  logic [31:0] refill_predecd,
  output logic        refill_done,
  input  logic        inv_req,
  output logic        inv_done,
  output logic        busy,
  output logic [15:0] ifu_icache_index,
  output logic        ifu_icache_predecd_array0_cen_b,
  output logic        ifu_icache_predecd_array0_wen_b,
  output logic [31:0] ifu_icache_predecd_array0_din,
  output logic        ifu_icache_predecd_array0_clk_en,
  input  logic [31:0] icache_ifu_predecd_array0_dout
);

  localparam int unsigned AW = WIDTH - 2;
  localparam int unsigned BW = $clog2(LINE_BEATS);
  localparam int unsigned IW = 16;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {IDLE, REFILL, INV} state_e;

  state_e        state;
  logic [AW-1:0] base_q;
  logic [AW-1:0] inv_cnt;
  logic [BW-1:0] beat_cnt;
  logic [AW-1:0] wr_addr;

  logic [DW-1:0] fifo_mem [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    fifo_cnt;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic wr_cand;
  logic wr_issue;
  logic force_wr;

  logic unused_line_bits;
  assign unused_line_bits = ^{refill_line_index[IW-1:WIDTH+1], refill_line_index[2:0]};

  assign fifo_full  = (fifo_cnt == 2'd2);
  assign fifo_empty = (fifo_cnt == 2'd0);
  assign refill_rdy = !fifo_full && (state == REFILL);
  assign push       = refill_vld && refill_rdy;
  assign wr_cand    = (state == REFILL) && !fifo_empty;
  assign fetch_gnt  = fetch_req && (state != INV) && !force_wr;
  assign wr_issue   = wr_cand && !fetch_gnt;
  assign pop        = wr_issue;
  assign busy       = (state != IDLE);
  assign rd_data    = rd_vld ? icache_ifu_predecd_array0_dout : '0;
  assign ifu_icache_predecd_array0_clk_en = !ifu_icache_predecd_array0_cen_b | rd_vld;

  // Beat offset wraps inside the line; upper address bits come from the latched base.
  assign wr_addr = {base_q[AW-1:BW], BW'(base_q[BW-1:0] + beat_cnt)};

`ifdef IFU_PREDECD_STARVE_EN
  logic [2:0] starve_cnt;

  assign force_wr = wr_cand && (starve_cnt == 3'(STARVE_MAX));

  // Counts cycles a pending refill write loses to fetch.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      starve_cnt <= '0;
    end else if (wr_issue) begin
      starve_cnt <= '0;
    end else if (wr_cand && fetch_gnt) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end
`else
  logic [2:0] unused_starve_max;
  assign unused_starve_max = 3'(STARVE_MAX);
  assign force_wr          = 1'b0;
`endif

  // Array drive: invalidate sweep, then fetch, then refill write.
  always_comb begin
    ifu_icache_predecd_array0_cen_b = 1'b1;
    ifu_icache_predecd_array0_wen_b = 1'b1;
    ifu_icache_index                = '0;
    ifu_icache_predecd_array0_din   = '0;
    if (state == INV) begin
      ifu_icache_predecd_array0_cen_b = 1'b0;
      ifu_icache_predecd_array0_wen_b = 1'b0;
      ifu_icache_index                = IW'({inv_cnt, 3'b000});
    end else if (fetch_gnt) begin
      ifu_icache_predecd_array0_cen_b = 1'b0;
      ifu_icache_index                = fetch_index;
    end else if (wr_issue) begin
      ifu_icache_predecd_array0_cen_b = 1'b0;
      ifu_icache_predecd_array0_wen_b = 1'b0;
      ifu_icache_index                = IW'({wr_addr, 3'b000});
      ifu_icache_predecd_array0_din   = fifo_mem[rd_ptr];
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state       <= IDLE;
      base_q      <= '0;
      beat_cnt    <= '0;
      inv_cnt     <= '0;
      rd_vld      <= 1'b0;
      refill_done <= 1'b0;
      inv_done    <= 1'b0;
    end else begin
      rd_vld      <= fetch_gnt;
      refill_done <= 1'b0;
      inv_done    <= 1'b0;
      case (state)
        IDLE: begin
          if (inv_req) begin
            state   <= INV;
            inv_cnt <= '0;
          end else if (refill_start) begin
            state    <= REFILL;
            base_q   <= refill_line_index[WIDTH:3];
            beat_cnt <= '0;
          end
        end
        REFILL: begin
          if (wr_issue) begin
            beat_cnt <= beat_cnt + BW'(1);
            if (&beat_cnt) begin
              state       <= IDLE;
              refill_done <= 1'b1;
            end
          end
        end
        INV: begin
          inv_cnt <= inv_cnt + AW'(1);
          if (&inv_cnt) begin
            state    <= IDLE;
            inv_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-entry refill FIFO; simultaneous push and pop keeps the count.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= refill_predecd;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_ct_ifu_icache_predecd_wr_ctrl.sv
// Directed self-checking bench for ct_ifu_icache_predecd_wr_ctrl (WIDTH=12, LINE_BEATS=4).
module tb_ct_ifu_icache_predecd_wr_ctrl;

  logic        clk = 1'b0;
  logic        cpurst;
  logic        fetch_req;
  logic [15:0] fetch_index;
  logic        fetch_gnt;
  logic        rd_vld;
  logic [31:0] rd_data;
  logic        refill_start;
  logic [15:0] refill_line_index;
  logic        refill_vld;
  logic        refill_rdy;
  logic [31:0] refill_predecd;
  logic        refill_done;
  logic        inv_req;
  logic        inv_done;
  logic        busy;
  logic [15:0] index;
  logic        cen_b;
  logic        wen_b;
  logic [31:0] din;
  logic        clk_en;
  logic [31:0] dout;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ct_ifu_icache_predecd_wr_ctrl dut (
    .forever_cpuclk                  (clk),
    .cpurst                          (cpurst),
    .fetch_req                       (fetch_req),
    .fetch_index                     (fetch_index),
    .fetch_gnt                       (fetch_gnt),
    .rd_vld                          (rd_vld),
    .rd_data                         (rd_data),
    .refill_start                    (refill_start),
    .refill_line_index               (refill_line_index),
    .refill_vld                      (refill_vld),
    .refill_rdy                      (refill_rdy),
    .refill_predecd                  (refill_predecd),
    .refill_done                     (refill_done),
    .inv_req                         (inv_req),
    .inv_done                        (inv_done),
    .busy                            (busy),
    .ifu_icache_index                (index),
    .ifu_icache_predecd_array0_cen_b (cen_b),
    .ifu_icache_predecd_array0_wen_b (wen_b),
    .ifu_icache_predecd_array0_din   (din),
    .ifu_icache_predecd_array0_clk_en(clk_en),
    .icache_ifu_predecd_array0_dout  (dout)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] aw [4];
  logic [31:0] bw [4];
  logic [31:0] cw [4];
  int nw, k1, k2, gnt_cnt, gnt_bad, nwt, nb, rdone, err;
  logic pushed;

  initial begin
    aw[0] = 32'hA0A0_0000; aw[1] = 32'hA1A1_1111; aw[2] = 32'hA2A2_2222; aw[3] = 32'hA3A3_3333;
    bw[0] = 32'hB000_0B00; bw[1] = 32'hB111_1B11; bw[2] = 32'hB222_2B22; bw[3] = 32'hB333_3B33;
    cw[0] = 32'hC0C0_C0C0; cw[1] = 32'hC1C1_C1C1; cw[2] = 32'hC2C2_C2C2; cw[3] = 32'hC3C3_C3C3;

    cpurst = 1'b1; fetch_req = 1'b0; fetch_index = '0; refill_start = 1'b0;
    refill_line_index = '0; refill_vld = 1'b0; refill_predecd = '0; inv_req = 1'b0; dout = '0;
    tick(); tick();
    chk("rst_busy",   32'(busy), 0);
    chk("rst_cen_b",  32'(cen_b), 1);
    chk("rst_wen_b",  32'(wen_b), 1);
    chk("rst_index",  32'(index), 0);
    chk("rst_din",    din, 0);
    chk("rst_rd_vld", 32'(rd_vld), 0);
    chk("rst_rdy",    32'(refill_rdy), 0);
    chk("rst_clk_en", 32'(clk_en), 0);

    // Fetch read
    cpurst = 1'b0; fetch_req = 1'b1; fetch_index = 16'h0048; #1;
    chk("rd_gnt",    32'(fetch_gnt), 1);
    chk("rd_cen_b",  32'(cen_b), 0);
    chk("rd_wen_b",  32'(wen_b), 1);
    chk("rd_index",  32'(index), 32'h48);
    chk("rd_clk_en", 32'(clk_en), 1);
    tick();
    fetch_req = 1'b0; dout = 32'hDEAD_BEEF; #1;
    chk("rd_vld",        32'(rd_vld), 1);
    chk("rd_data",       rd_data, 32'hDEAD_BEEF);
    chk("rd_vld_clk_en", 32'(clk_en), 1);
    tick();
    chk("rd_vld_drop",  32'(rd_vld), 0);
    chk("rd_data_zero", rd_data, 0);

    // Refill line at base 0x0040, no fetch traffic
    refill_start = 1'b1; refill_line_index = 16'h0040;
    tick();
    refill_start = 1'b0; refill_vld = 1'b1; refill_predecd = aw[0]; #1;
    chk("rf_busy",       32'(busy), 1);
    chk("rf_rdy",        32'(refill_rdy), 1);
    chk("rf_empty_idle", 32'(cen_b), 1);
    for (int b = 0; b < 4; b++) begin
      tick();
      if (b < 3) refill_predecd = aw[b+1];
      else refill_vld = 1'b0;
      #1;
      chk("rf_wen_b",  32'(wen_b), 0);
      chk("rf_index",  32'(index), 32'h40 + 32'(b * 8));
      chk("rf_din",    din, aw[b]);
      chk("rf_nodone", 32'(refill_done), 0);
    end
    tick();
    chk("rf_done",      32'(refill_done), 1);
    chk("rf_done_busy", 32'(busy), 0);
    tick();
    chk("rf_done_pulse", 32'(refill_done), 0);

    // FIFO fill under fetch pressure, then drain with push+pop overlap
    refill_start = 1'b1; refill_line_index = 16'h0100;
    tick();
    refill_start = 1'b0; fetch_req = 1'b1; fetch_index = 16'h0010;
    refill_vld = 1'b1; refill_predecd = bw[0]; #1;
    chk("ff_rdy0", 32'(refill_rdy), 1);
    tick();
    refill_predecd = bw[1]; #1;
    chk("ff_rdy1",   32'(refill_rdy), 1);
    chk("ff_gnt",    32'(fetch_gnt), 1);
    chk("ff_read",   32'(wen_b), 1);
    tick();
    refill_predecd = bw[2]; #1;
    chk("ff_full_rdy", 32'(refill_rdy), 0);
    tick();
    fetch_req = 1'b0; #1;
    chk("ff_w0_idx", 32'(index), 32'h100);
    chk("ff_w0_din", din, bw[0]);
    chk("ff_w0_rdy", 32'(refill_rdy), 0);
    tick();
    #1;
    chk("ff_w1_din", din, bw[1]);
    chk("ff_w1_rdy", 32'(refill_rdy), 1);
    tick();
    refill_predecd = bw[3]; #1;
    chk("ff_w2_din", din, bw[2]);
    chk("ff_w2_idx", 32'(index), 32'h110);
    chk("ff_w2_rdy", 32'(refill_rdy), 1);
    tick();
    refill_vld = 1'b0; #1;
    chk("ff_w3_din", din, bw[3]);
    chk("ff_w3_idx", 32'(index), 32'h118);
    tick();
    chk("ff_done", 32'(refill_done), 1);
    chk("ff_busy", 32'(busy), 0);

    // Refill starved by continuous fetch
    refill_start = 1'b1; refill_line_index = 16'h0200;
    tick();
    refill_start = 1'b0; fetch_req = 1'b1; fetch_index = 16'h0008;
    refill_vld = 1'b1; refill_predecd = cw[0];
    tick();
    refill_predecd = cw[1];
    tick();
    refill_vld = 1'b0;
    nw = 0; k1 = -1; k2 = -1; gnt_cnt = 0; gnt_bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (fetch_gnt) gnt_cnt++;
      if (!cen_b && !wen_b) begin
        nw++;
        if (nw == 1) k1 = k;
        else k2 = k;
        if (fetch_gnt) gnt_bad++;
      end
      tick();
    end
`ifdef IFU_PREDECD_STARVE_EN
    chk("sv_nwrites", 32'(nw), 2);
    chk("sv_first",   32'(k1), 6);
    chk("sv_gap",     32'(k2 - k1), 8);
    chk("sv_gnt_bad", 32'(gnt_bad), 0);
    chk("sv_gnt_cnt", 32'(gnt_cnt), 18);
`else
    chk("sv_nwrites", 32'(nw), 0);
    chk("sv_gnt_cnt", 32'(gnt_cnt), 20);
`endif
    fetch_req = 1'b0;
    nb = 2; nwt = 0; rdone = 0;
    for (int c = 0; c < 30; c++) begin
      refill_vld = (nb < 4);
      refill_predecd = cw[nb[1:0]];
      #1;
      pushed = refill_vld && refill_rdy;
      if (!cen_b && !wen_b) nwt++;
      tick();
      if (pushed) nb++;
      if (refill_done) rdone++;
    end
    refill_vld = 1'b0;
    chk("sv_total_wr", 32'(nw + nwt), 4);
    chk("sv_done_cnt", 32'(rdone), 1);
    chk("sv_busy",     32'(busy), 0);

    // Invalidate sweep; same-cycle refill_start dropped, fetch held off
    inv_req = 1'b1; refill_start = 1'b1; refill_line_index = 16'h0040;
    tick();
    inv_req = 1'b0; refill_start = 1'b0; fetch_req = 1'b1; fetch_index = 16'h0030;
    chk("inv_busy", 32'(busy), 1);
    chk("inv_rdy",  32'(refill_rdy), 0);
    err = 0;
    for (int i = 0; i < 1024; i++) begin
      if (cen_b !== 1'b0 || wen_b !== 1'b0 || index !== 16'(i << 3) ||
          din !== 32'h0 || fetch_gnt !== 1'b0 || inv_done !== 1'b0) err++;
      tick();
    end
    chk("inv_sweep_err", 32'(err), 0);
    chk("inv_done",      32'(inv_done), 1);
    chk("inv_idle",      32'(busy), 0);
    chk("inv_gnt_back",  32'(fetch_gnt), 1);
    tick();
    chk("inv_done_pulse", 32'(inv_done), 0);
    chk("inv_no_refill",  32'(busy), 0);
    fetch_req = 1'b0;

    // Reset in the middle of a line
    refill_start = 1'b1; refill_line_index = 16'h0040;
    tick();
    refill_start = 1'b0; fetch_req = 1'b1; refill_vld = 1'b1; refill_predecd = aw[0];
    tick();
    refill_predecd = aw[1];
    tick();
    refill_vld = 1'b0; #1;
    chk("mr_full", 32'(refill_rdy), 0);
    cpurst = 1'b1; fetch_req = 1'b0;
    tick();
    chk("mr_busy",  32'(busy), 0);
    chk("mr_rdy",   32'(refill_rdy), 0);
    chk("mr_cen_b", 32'(cen_b), 1);
    chk("mr_done",  32'(refill_done), 0);
    cpurst = 1'b0;
    tick();
    refill_start = 1'b1; refill_line_index = 16'h0040;
    tick();
    refill_start = 1'b0; #1;
    chk("mr_new_busy",  32'(busy), 1);
    chk("mr_fifo_empty", 32'(cen_b), 1);
    chk("mr_new_rdy",   32'(refill_rdy), 1);
    chk("mr_no_done",   32'(refill_done), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
